counter_seq_ctrl: RTL and testbench
===================================

Name: counter_seq_ctrl

Overview:
- Sequencing controller for the 8-bit up/down loadable counter datapath of the counter/scan display design.
- Converts three debounced push-button levels (run, load, mode) into single-cycle control strobes for the counter: count enable, load, and direction.
- Contains the 1 Hz step prescaler, so the counter runs on the 100 MHz system clock with an enable strobe instead of a divided clock.
- Sits between the debounce instances and the counter; its state is also exported for display and LEDs.

Parameters:
- TICK_DIV, 100_000_000: clk cycles per count step (1 Hz at 100 MHz). Must be ≥ 2.
- WIDTH, 8: counter width, matching the count input.
- LIMIT, 8'hFF: terminal count, used only with AUTO_STOP_EN.

Ports:
- clk  in  1  system clock, 100 MHz.
- clr  in  1  reset; synchronous, active-high.
- run_btn  in  1  debounced level, synchronous to clk; a rising edge toggles run/pause.
- load_btn  in  1  debounced level; a rising edge requests a load.
- mode_btn  in  1  debounced level; a rising edge toggles count direction.
- count  in  WIDTH  current counter value (used only with AUTO_STOP_EN).
- cnt_en  out  1  one-cycle step strobe to the counter.
- cnt_load  out  1  one-cycle load strobe to the counter.
- cnt_dir  out  1  count direction: 0 = up, 1 = down.
- state  out  2  FSM state: IDLE=0, RUN=1, PAUSE=2, LOAD=3.
- done  out  1  one-cycle terminal-count strobe.

Behaviour:
- Reset (clr high at a clk edge):
  - state=IDLE; cnt_en=0, cnt_load=0, cnt_dir=0, done=0; prescaler=0.
  - Edge-detect registers are set to 1, so a button held through reset gives no event until it is released and pressed again.
  - clr overrides all other activity, including in LOAD and on a tick cycle.
- Edge detection:
  - rise = level & ~prev, with prev registered every cycle.
  - The resulting state/output change is visible after the same edge that samples the high level (1-cycle latency from the input).
- Event priority in one cycle: load > run. Mode is independent of run.
  - A mode rise in the same cycle as a load rise is dropped.
  - A run rise in the same cycle as a load rise is dropped.
- FSM transitions:
  - IDLE: run rise → RUN, with the prescaler cleared.
  - RUN: run rise → PAUSE.
  - PAUSE: run rise → RUN, with the prescaler resumed from its held value (not cleared).
  - Any non-LOAD state: load rise → LOAD. A from_run flag records whether the source was RUN or PAUSE.
  - LOAD lasts exactly 1 cycle, with cnt_load=1 during it. It then goes to PAUSE if from_run, else IDLE. Button rises during LOAD are ignored.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN, wrapping to 0.
  - Holds in PAUSE; cleared in IDLE and LOAD.
  - tick = (prescaler == TICK_DIV-1) while in RUN.
- cnt_en:
  - Registered; high for exactly 1 cycle following each tick.
  - First strobe comes TICK_DIV cycles after the IDLE→RUN transition, then every TICK_DIV cycles.
  - Never high outside RUN-sourced ticks.
  - If a tick coincides with a run rise (→PAUSE), the strobe still fires for that tick.
- cnt_dir: toggles on a mode rise in IDLE, RUN or PAUSE; holds its value otherwise.
- Width/wrap: the controller never inspects count except under AUTO_STOP_EN. Counter wrap-around (FF↔00) is the datapath's responsibility.
- done = 0 when AUTO_STOP_EN is not defined.

Optional Feature:
- Macro: COUNTER_SEQ_CTRL_AUTO_STOP_EN.
- Defined: on a tick in RUN where the next step would reach the terminal count, the controller does the following.
  - Terminal condition: count == LIMIT-1 when cnt_dir=0, or count == 1 when cnt_dir=1.
  - cnt_en fires, then state → PAUSE, with done high for 1 cycle coincident with that cnt_en.
  - A later run rise resumes normally.
- Undefined: the count input is unused, done is tied 0, and the counter free-runs with wrap.

Decomposition:
- Shared package counter_pkg:
  - State encodings ST_IDLE, ST_RUN, ST_PAUSE, ST_LOAD as 2-bit localparams.
  - DIR_UP/DIR_DOWN constants.
  - Default TICK_DIV.
- One natural sub-module: tick_prescaler.
  - Parameter TICK_DIV.
  - Inputs clk, clr, run, clear_cnt.
  - Output tick.
  - The FSM and edge detection stay in counter_seq_ctrl.

Test Plan (TICK_DIV=4, LIMIT=8'h05):
- Reset with run_btn held high, then keep it held → state=0, no RUN until release and re-press; all outputs 0.
- Run rise from IDLE → state=1 next cycle; cnt_en pulses at cycles +4, +8, +12, each exactly 1 cycle wide.
- In RUN, pause after 2 prescaler counts, wait 10 cycles, resume → no cnt_en while paused; next cnt_en 2 cycles after resume.
- Load and mode rises in the same cycle during RUN → state=3 for 1 cycle with cnt_load=1, then state=2; cnt_dir unchanged.
- Mode rise in PAUSE → cnt_dir 0→1; a second rise returns it to 0; cnt_en stays 0.
- AUTO_STOP_EN defined, count driven to 4, up, tick → cnt_en and done both high for 1 cycle, then state=2; undefined build → state stays 1 and done=0.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter sequencing controller: FSM state
// encodings, count-direction constants and the default step divider.
package counter_pkg;

    // FSM state encoding, also exported on the state output
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LOAD  = 2'd3
    } state_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // 1 Hz step at a 100 MHz system clock
    localparam int unsigned TICK_DIV_DEFAULT = 100_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Step prescaler: counts 0..TICK_DIV-1 while run is high, holds while run is
// low, and is forced to zero by clear_cnt. tick marks the last count in run.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic clr,
    input  logic run,
    input  logic clear_cnt,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Prescale counter: clear, advance-with-wrap in run, otherwise hold
    always_ff @(posedge clk) begin
        if (clr || clear_cnt) begin
            r_cnt <= '0;
        end else if (run) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign tick = run && (r_cnt == LAST);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencing controller for the up/down loadable counter: turns debounced
// run/load/mode button levels into count-enable, load and direction controls.
// Optional macro COUNTER_SEQ_CTRL_AUTO_STOP_EN pauses the sequence and pulses
// done on the step that reaches the terminal count.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int unsigned     TICK_DIV = TICK_DIV_DEFAULT,
    parameter int unsigned     WIDTH    = 8,
    parameter logic [WIDTH-1:0] LIMIT   = '1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run_btn,
    input  logic             load_btn,
    input  logic             mode_btn,
    input  logic [WIDTH-1:0] count,
    output logic             cnt_en,
    output logic             cnt_load,
    output logic             cnt_dir,
    output logic [1:0]       state,
    output logic             done
);

    state_t r_state;
    state_t w_state_d;
    logic   r_run_prev;
    logic   r_load_prev;
    logic   r_mode_prev;
    logic   r_from_run;
    logic   r_cnt_en;
    logic   r_cnt_dir;
    logic   w_run_rise;
    logic   w_load_rise;
    logic   w_mode_rise;
    logic   w_dir_toggle;
    logic   w_tick;
    logic   w_terminal;
    logic   w_in_run;
    logic   w_clear_cnt;

    assign w_run_rise  = run_btn & ~r_run_prev;
    assign w_load_rise = load_btn & ~r_load_prev;
    assign w_mode_rise = mode_btn & ~r_mode_prev;

    assign w_in_run    = (r_state == ST_RUN);
    assign w_clear_cnt = (r_state == ST_IDLE) || (r_state == ST_LOAD);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk       (clk),
        .clr       (clr),
        .run       (w_in_run),
        .clear_cnt (w_clear_cnt),
        .tick      (w_tick)
    );

`ifdef COUNTER_SEQ_CTRL_AUTO_STOP_EN
    logic w_at_limit;
    logic r_done;

    // Next step lands on the terminal count in the current direction
    assign w_at_limit = (r_cnt_dir == DIR_DOWN) ? (count == WIDTH'(1))
                                                : (count == LIMIT - 1'b1);
    assign w_terminal = w_tick & w_at_limit;

    // done coincides with the cnt_en of the terminal step
    always_ff @(posedge clk) begin
        if (clr) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_terminal;
        end
    end

    assign done = r_done;
`else
    logic w_unused_count;

    assign w_unused_count = ^{count, LIMIT};
    assign w_terminal     = 1'b0;
    assign done           = 1'b0;
`endif

    // Next-state decode; load outranks run, and a load rise also swallows mode
    always_comb begin
        w_state_d    = r_state;
        w_dir_toggle = 1'b0;
        unique case (r_state)
            ST_LOAD: w_state_d = r_from_run ? ST_PAUSE : ST_IDLE;
            default: begin
                if (w_load_rise) begin
                    w_state_d = ST_LOAD;
                end else begin
                    w_dir_toggle = w_mode_rise;
                    if (w_run_rise) begin
                        w_state_d = (r_state == ST_RUN) ? ST_PAUSE : ST_RUN;
                    end else if (w_terminal) begin
                        w_state_d = ST_PAUSE;
                    end
                end
            end
        endcase
    end

    // State, edge-detect history, direction and step strobe registers
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state     <= ST_IDLE;
            r_run_prev  <= 1'b1;  // held buttons must be released before they count
            r_load_prev <= 1'b1;
            r_mode_prev <= 1'b1;
            r_from_run  <= 1'b0;
            r_cnt_en    <= 1'b0;
            r_cnt_dir   <= DIR_UP;
        end else begin
            r_state     <= w_state_d;
            r_run_prev  <= run_btn;
            r_load_prev <= load_btn;
            r_mode_prev <= mode_btn;
            r_cnt_en    <= w_tick;
            if ((r_state != ST_LOAD) && w_load_rise) begin
                r_from_run <= (r_state == ST_RUN);
            end
            if (w_dir_toggle) begin
                r_cnt_dir <= (r_cnt_dir == DIR_UP) ? DIR_DOWN : DIR_UP;
            end
        end
    end

    assign state    = r_state;
    assign cnt_en   = r_cnt_en;
    assign cnt_load = (r_state == ST_LOAD);
    assign cnt_dir  = r_cnt_dir;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Self-checking bench for counter_seq_ctrl with TICK_DIV=4, LIMIT=8'h05.
// Honours COUNTER_SEQ_CTRL_AUTO_STOP_EN when defined for the build.
module tb_counter_seq_ctrl;

    localparam int unsigned TD  = 4;
    localparam logic [7:0]  LIM = 8'h05;
`ifdef COUNTER_SEQ_CTRL_AUTO_STOP_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       clr;
    logic       run_btn;
    logic       load_btn;
    logic       mode_btn;
    logic [7:0] count;
    logic       cnt_en;
    logic       cnt_load;
    logic       cnt_dir;
    logic [1:0] state;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    counter_seq_ctrl #(
        .TICK_DIV (TD),
        .WIDTH    (8),
        .LIMIT    (LIM)
    ) dut (
        .clk      (clk),
        .clr      (clr),
        .run_btn  (run_btn),
        .load_btn (load_btn),
        .mode_btn (mode_btn),
        .count    (count),
        .cnt_en   (cnt_en),
        .cnt_load (cnt_load),
        .cnt_dir  (cnt_dir),
        .state    (state),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clr = 1'b1; run_btn = 1'b0; load_btn = 1'b0; mode_btn = 1'b0; count = 8'd0;
        cyc();
        cyc();
        clr = 1'b0;
        cyc();
    endtask

    // Observation vector: {state, cnt_en, cnt_load, cnt_dir, done}
    task automatic test_reset();
        clr = 1'b1; run_btn = 1'b1; load_btn = 1'b0; mode_btn = 1'b0; count = 8'd0;
        cyc();
        cyc();
        n_checks++;
        if ({state, cnt_en, cnt_load, cnt_dir, done} !== 6'b00_0000) begin
            n_fail++;
            $display("FAIL reset_state: got %b expected %b",
                     {state, cnt_en, cnt_load, cnt_dir, done}, 6'b00_0000);
        end
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            n_checks++;
            if ({state, cnt_en, cnt_load, cnt_dir, done} !== 6'b00_0000) begin
                n_fail++;
                $display("FAIL reset_held_btn cycle %0d: got %b expected %b", i,
                         {state, cnt_en, cnt_load, cnt_dir, done}, 6'b00_0000);
            end
        end
        run_btn = 1'b0;
        cyc();
        n_checks++;
        if (state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_release: state got %0d expected 0", state);
        end
        run_btn = 1'b1;
        cyc();
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL reset_repress: state got %0d expected 1", state);
        end
    endtask

    task automatic test_run_strobes();
        do_reset();
        run_btn = 1'b1;
        cyc();
        n_checks++;
        if ({state, cnt_en} !== 3'b01_0) begin
            n_fail++;
            $display("FAIL run_start: got %b expected %b", {state, cnt_en}, 3'b01_0);
        end
        for (int k = 1; k <= 12; k++) begin
            cyc();
            n_checks++;
            if ({state, cnt_en} !== {2'd1, (k % TD) == 0}) begin
                n_fail++;
                $display("FAIL run_strobe cycle +%0d: got %b expected %b", k,
                         {state, cnt_en}, {2'd1, (k % TD) == 0});
            end
        end
        run_btn = 1'b0;
    endtask

    task automatic test_pause_resume();
        do_reset();
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        cyc();
        run_btn = 1'b1;
        cyc();
        n_checks++;
        if ({state, cnt_en} !== 3'b10_0) begin
            n_fail++;
            $display("FAIL pause_enter: got %b expected %b", {state, cnt_en}, 3'b10_0);
        end
        run_btn = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            n_checks++;
            if ({state, cnt_en} !== 3'b10_0) begin
                n_fail++;
                $display("FAIL pause_hold cycle %0d: got %b expected %b", i,
                         {state, cnt_en}, 3'b10_0);
            end
        end
        run_btn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            n_checks++;
            if ({state, cnt_en} !== {2'd1, k == 2}) begin
                n_fail++;
                $display("FAIL resume cycle +%0d: got %b expected %b", k,
                         {state, cnt_en}, {2'd1, k == 2});
            end
        end
        run_btn = 1'b0;
    endtask

    task automatic test_load_mode();
        do_reset();
        run_btn = 1'b1;
        cyc();
        load_btn = 1'b1;
        mode_btn = 1'b1;
        cyc();
        n_checks++;
        if ({state, cnt_load, cnt_dir} !== 4'b11_1_0) begin
            n_fail++;
            $display("FAIL load_cycle: got %b expected %b",
                     {state, cnt_load, cnt_dir}, 4'b11_1_0);
        end
        cyc();
        n_checks++;
        if ({state, cnt_load, cnt_dir} !== 4'b10_0_0) begin
            n_fail++;
            $display("FAIL load_exit: got %b expected %b",
                     {state, cnt_load, cnt_dir}, 4'b10_0_0);
        end
        run_btn = 1'b0; load_btn = 1'b0; mode_btn = 1'b0;
    endtask

    task automatic test_mode_pause();
        do_reset();
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        cyc();
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        mode_btn = 1'b1;
        cyc();
        n_checks++;
        if ({state, cnt_en, cnt_dir} !== 4'b10_0_1) begin
            n_fail++;
            $display("FAIL mode_toggle1: got %b expected %b",
                     {state, cnt_en, cnt_dir}, 4'b10_0_1);
        end
        mode_btn = 1'b0;
        cyc();
        n_checks++;
        if ({state, cnt_en, cnt_dir} !== 4'b10_0_1) begin
            n_fail++;
            $display("FAIL mode_hold: got %b expected %b",
                     {state, cnt_en, cnt_dir}, 4'b10_0_1);
        end
        mode_btn = 1'b1;
        cyc();
        n_checks++;
        if ({state, cnt_en, cnt_dir} !== 4'b10_0_0) begin
            n_fail++;
            $display("FAIL mode_toggle2: got %b expected %b",
                     {state, cnt_en, cnt_dir}, 4'b10_0_0);
        end
        mode_btn = 1'b0;
    endtask

    task automatic test_auto_stop();
        do_reset();
        count   = 8'd4;
        run_btn = 1'b1;
        cyc();
        run_btn = 1'b0;
        for (int k = 1; k < 4; k++) cyc();
        cyc();
        n_checks++;
        if ({cnt_en, done} !== {1'b1, AUTO}) begin
            n_fail++;
            $display("FAIL auto_strobe: got %b expected %b", {cnt_en, done}, {1'b1, AUTO});
        end
        cyc();
        n_checks++;
        if ({state, cnt_en, done} !== {AUTO ? 2'd2 : 2'd1, 2'b00}) begin
            n_fail++;
            $display("FAIL auto_after: got %b expected %b", {state, cnt_en, done},
                     {AUTO ? 2'd2 : 2'd1, 2'b00});
        end
        count   = 8'd0;
        run_btn = 1'b1;
        cyc();
        n_checks++;
        if (state !== (AUTO ? 2'd1 : 2'd2)) begin
            n_fail++;
            $display("FAIL auto_resume: state got %0d expected %0d", state,
                     AUTO ? 2'd1 : 2'd2);
        end
        run_btn = 1'b0;
    endtask

    // Random buttons/count/clear against a behavioural model of the rules
    task automatic test_random();
        int   m_mode;  // 0 idle, 1 run, 2 pause, 3 load
        int   m_run_cycles;
        bit   m_pr, m_pl, m_pm, m_dir, m_from, m_en, m_done;
        int   n_mode, n_run_cycles;
        bit   n_dir, n_from, n_en, n_done;
        bit   rr, lr, mr, tick, term;
        logic [5:0] exp_v;
        do_reset();
        m_mode = 0; m_run_cycles = 0; m_pr = 0; m_pl = 0; m_pm = 0;
        m_dir = 0; m_from = 0; m_en = 0; m_done = 0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 5) == 0) run_btn = ~run_btn;
            if ($urandom_range(0, 7) == 0) load_btn = ~load_btn;
            if ($urandom_range(0, 5) == 0) mode_btn = ~mode_btn;
            count = 8'($urandom_range(0, 7));
            clr   = ($urandom_range(0, 79) == 0);
            if (clr) begin
                n_mode = 0; n_run_cycles = 0; n_dir = 0; n_from = m_from;
                n_en = 0; n_done = 0;
                m_pr = 1; m_pl = 1; m_pm = 1;
            end else begin
                rr   = run_btn && !m_pr;
                lr   = load_btn && !m_pl;
                mr   = mode_btn && !m_pm;
                tick = (m_mode == 1) && ((m_run_cycles % TD) == TD - 1);
                term = AUTO && tick && (m_dir ? (count == 8'd1) : (count == LIM - 8'd1));
                n_en = tick;
                n_done = term;
                n_dir  = m_dir;
                n_from = m_from;
                n_mode = m_mode;
                if (m_mode == 3) begin
                    n_mode = m_from ? 2 : 0;
                end else if (lr) begin
                    n_from = (m_mode == 1);
                    n_mode = 3;
                end else begin
                    if (mr) n_dir = !m_dir;
                    if (rr) n_mode = (m_mode == 1) ? 2 : 1;
                    else if (term) n_mode = 2;
                end
                if (m_mode == 1) n_run_cycles = m_run_cycles + 1;
                else if (m_mode == 2) n_run_cycles = m_run_cycles;
                else n_run_cycles = 0;
                m_pr = run_btn; m_pl = load_btn; m_pm = mode_btn;
            end
            cyc();
            m_mode = n_mode; m_run_cycles = n_run_cycles; m_dir = n_dir; m_from = n_from;
            m_en = n_en; m_done = n_done;
            exp_v = {2'(m_mode), m_en, m_mode == 3, m_dir, m_done};
            n_checks++;
            if ({state, cnt_en, cnt_load, cnt_dir, done} !== exp_v) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b expected %b", i,
                         {state, cnt_en, cnt_load, cnt_dir, done}, exp_v);
            end
        end
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run_strobes();
        test_pause_resume();
        test_load_mode();
        test_mode_pause();
        test_auto_stop();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
